// File: rtl/sample_pair_packer_pkg.sv
// Shared types for the DWT 9/7 front end: FSM state encoding and the
// {eol, sof, even, odd} pair record used to describe packed output beats.
package Dwt97Pkg;

  localparam int unsigned SampleWidth = 16;

  typedef logic signed [SampleWidth-1:0] sample_t;

  typedef struct packed {
    logic    eol;
    logic    sof;
    sample_t even;
    sample_t odd;
  } pair_t;

  typedef enum logic {
    ST_EVEN = 1'b0,
    ST_ODD  = 1'b1
  } state_e;

endpackage

// File: rtl/sample_pair_packer_axis_reg.sv
// AxisReg: single-entry valid/ready output register. Loads whenever the
// producer pushes, drains on ready, and holds its payload while stalled.
module AxisReg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o
);

  // Load has priority so a same-cycle drain and refill keeps valid high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_o;
    end
  end

endmodule

// File: rtl/sample_pair_packer.sv
// Packs a line-structured sample stream into {odd, even} pairs for the 1D
// lifting unit. Optional line-length checker: SAMPLE_PAIR_PACKER_LEN_CHECK_EN.
module sample_pair_packer
  import Dwt97Pkg::*;
#(
  parameter int unsigned DataWidth       = 16,
  parameter int unsigned MaximumSideSize = 512
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  output logic                   s_ready_o,
  input  logic                   s_valid_i,
  input  logic                   s_sof_i,
  input  logic                   s_eol_i,
  input  logic [DataWidth-1:0]   s_data_i,
  input  logic                   m_ready_i,
  output logic                   m_valid_o,
  output logic                   m_sof_o,
  output logic                   m_eol_o,
  output logic [2*DataWidth-1:0] m_data_o
`ifdef SAMPLE_PAIR_PACKER_LEN_CHECK_EN
  ,
  output logic                   err_o
`endif
);

  localparam int unsigned PayloadWidth = 2 * DataWidth + 2;

  state_e                  r_state, w_state_next;
  logic [DataWidth-1:0]    r_even_hold, w_even_hold_next;
  logic [DataWidth-1:0]    r_last_odd, w_last_odd_next;
  logic                    r_sof_hold, w_sof_hold_next;
  logic                    r_last_odd_vld, w_last_odd_vld_next;
  logic                    w_accept;
  logic                    w_load;
  logic [PayloadWidth-1:0] w_payload;
  logic [PayloadWidth-1:0] w_out;

  assign s_ready_o = ~m_valid_o | m_ready_i;
  assign w_accept  = s_valid_i & s_ready_o;

  // A sof seen while holding an even sample restarts the line as if in EVEN.
  always_comb begin
    w_state_next        = r_state;
    w_even_hold_next    = r_even_hold;
    w_sof_hold_next     = r_sof_hold;
    w_last_odd_next     = r_last_odd;
    w_last_odd_vld_next = r_last_odd_vld;
    w_load              = 1'b0;
    w_payload           = '0;
    if (w_accept) begin
      if ((r_state == ST_ODD) && !s_sof_i) begin
        w_load              = 1'b1;
        w_payload           = {s_eol_i, r_sof_hold, s_data_i, r_even_hold};
        w_last_odd_next     = s_data_i;
        w_last_odd_vld_next = ~s_eol_i;
        w_state_next        = ST_EVEN;
      end else if (!s_eol_i) begin
        w_even_hold_next    = s_data_i;
        w_sof_hold_next     = s_sof_i;
        w_last_odd_vld_next = r_last_odd_vld & ~s_sof_i;
        w_state_next        = ST_ODD;
      end else begin
        // Odd-length line end: mirror x[N-2], or duplicate a lone sample.
        w_load              = 1'b1;
        w_last_odd_vld_next = 1'b0;
        w_state_next        = ST_EVEN;
        if (r_last_odd_vld && !s_sof_i) begin
          w_payload = {1'b1, 1'b0, r_last_odd, s_data_i};
        end else begin
          w_payload = {1'b1, s_sof_i, s_data_i, s_data_i};
        end
      end
    end else begin
      w_load = 1'b0;
    end
  end

  // FSM state and sample holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= ST_EVEN;
      r_even_hold    <= '0;
      r_sof_hold     <= 1'b0;
      r_last_odd     <= '0;
      r_last_odd_vld <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_even_hold    <= w_even_hold_next;
      r_sof_hold     <= w_sof_hold_next;
      r_last_odd     <= w_last_odd_next;
      r_last_odd_vld <= w_last_odd_vld_next;
    end
  end

  AxisReg #(
    .Width(PayloadWidth)
  ) u_out_reg (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (w_load),
    .data_i (w_payload),
    .ready_i(m_ready_i),
    .valid_o(m_valid_o),
    .data_o (w_out)
  );

  assign m_eol_o  = w_out[PayloadWidth-1];
  assign m_sof_o  = w_out[PayloadWidth-2];
  assign m_data_o = w_out[2*DataWidth-1:0];

`ifdef SAMPLE_PAIR_PACKER_LEN_CHECK_EN
  localparam int unsigned LineCntWidth = $clog2(MaximumSideSize + 1);
  localparam logic [LineCntWidth-1:0] LineCntMax = LineCntWidth'(MaximumSideSize);

  logic [LineCntWidth-1:0] r_line_cnt;
  logic [LineCntWidth-1:0] w_line_cnt_base;
  logic                    w_sof_in_odd;
  logic                    r_err;

  assign w_line_cnt_base = s_sof_i ? '0 : r_line_cnt;
  assign w_sof_in_odd    = s_sof_i & (r_state == ST_ODD);

  // Samples seen so far in the current line; saturates at the limit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_line_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_err <= r_err | (w_line_cnt_base == LineCntMax) | w_sof_in_odd;
      if (s_eol_i) begin
        r_line_cnt <= '0;
      end else if (w_line_cnt_base != LineCntMax) begin
        r_line_cnt <= w_line_cnt_base + LineCntWidth'(1);
      end else begin
        r_line_cnt <= w_line_cnt_base;
      end
    end else begin
      r_line_cnt <= r_line_cnt;
    end
  end

  assign err_o = r_err;
`endif

endmodule

// File: tb/tb_sample_pair_packer.sv
// Self-checking bench for sample_pair_packer: directed scenarios followed by
// randomized lines checked against a line-buffer reference model.
module tb_sample_pair_packer;
  import Dwt97Pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        s_ready_o;
  logic        s_valid_i = 1'b0;
  logic        s_sof_i = 1'b0;
  logic        s_eol_i = 1'b0;
  logic [15:0] s_data_i = '0;
  logic        m_ready_i = 1'b1;
  logic        m_valid_o;
  logic        m_sof_o;
  logic        m_eol_o;
  logic [31:0] m_data_o;
`ifdef SAMPLE_PAIR_PACKER_LEN_CHECK_EN
  logic        err_o;
`endif

  int    checks = 0;
  int    errors = 0;
  bit    rand_ready = 1'b0;
  int    line_q[$];
  bit    line_sof = 1'b0;
  pair_t exp_q[$];
  bit    prev_stall = 1'b0;
  pair_t prev_pair;

  sample_pair_packer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .s_ready_o(s_ready_o),
    .s_valid_i(s_valid_i),
    .s_sof_i  (s_sof_i),
    .s_eol_i  (s_eol_i),
    .s_data_i (s_data_i),
    .m_ready_i(m_ready_i),
    .m_valid_o(m_valid_o),
    .m_sof_o  (m_sof_o),
    .m_eol_o  (m_eol_o),
    .m_data_o (m_data_o)
`ifdef SAMPLE_PAIR_PACKER_LEN_CHECK_EN
    ,
    .err_o    (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic pair_t obs();
    pair_t p;
    p.eol  = m_eol_o;
    p.sof  = m_sof_o;
    p.even = m_data_o[15:0];
    p.odd  = m_data_o[31:16];
    return p;
  endfunction

  function automatic pair_t mk(input bit eol, input bit sof, input int even, input int odd);
    pair_t p;
    p.eol  = eol;
    p.sof  = sof;
    p.even = 16'(even);
    p.odd  = 16'(odd);
    return p;
  endfunction

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Reference model: a line is an array x[0..]; pairs are (x[2k], x[2k+1]),
  // an odd-length line ends with (x[N-1], x[N-2]), a 1-sample line with (x0, x0).
  task automatic model_beat(input int d, input bit sof, input bit eol,
                            output bit done, output pair_t p);
    int n;
    done = 1'b0;
    p    = '0;
    if (sof) begin
      line_q.delete();
      line_sof = 1'b1;
    end
    line_q.push_back(d);
    n = line_q.size();
    if (n % 2 == 0) begin
      done = 1'b1;
      p = mk(eol, line_sof && (n == 2), line_q[n-2], line_q[n-1]);
    end else if (eol) begin
      done = 1'b1;
      p = mk(1'b1, line_sof && (n == 1), line_q[n-1], (n == 1) ? line_q[0] : line_q[n-2]);
    end
    if (eol) begin
      line_q.delete();
      line_sof = 1'b0;
    end
    if (done) exp_q.push_back(p);
  endtask

  task automatic roll_ready();
    if (rand_ready) m_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input int d, input bit sof, input bit eol);
    bit    done;
    bit    acc;
    pair_t p;
    acc = 1'b0;
    done = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 16'(d);
    s_sof_i   = sof;
    s_eol_i   = eol;
    for (int c = 0; c < 200 && !acc; c++) begin
      @(negedge clk_i);
      if (s_ready_o) begin
        acc = 1'b1;
        model_beat(d, sof, eol, done, p);
      end
      @(posedge clk_i);
      #1;
      if (!acc) roll_ready();
    end
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
    s_eol_i   = 1'b0;
    checks++;
    assert (acc) else begin
      errors++;
      $error("FAIL accept_timeout observed=no_accept expected=accept data=%h", d);
    end
    if (acc && done) begin
      check("latency_valid", 64'(m_valid_o), 64'(1));
      check("latency_pair", 64'(obs()), 64'(p));
    end
    roll_ready();
  endtask

  task automatic idle();
    s_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    roll_ready();
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    #1;
    check("rst_valid", 64'(m_valid_o), 64'(0));
    check("rst_sready", 64'(s_ready_o), 64'(1));
    check("rst_outs", {30'd0, m_sof_o, m_eol_o, m_data_o}, 64'(0));
    exp_q.delete();
    line_q.delete();
    line_sof = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Output-side scoreboard: order, stall stability and the ready rule.
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(m_valid_o), 64'(1));
        check("hold_pair", 64'(obs()), 64'(prev_pair));
      end
      check("s_ready_rule", 64'(s_ready_o), 64'(!m_valid_o || m_ready_i));
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_pair observed=%h expected=none", obs());
        end else begin
          check("out_pair", 64'(obs()), 64'(exp_q.pop_front()));
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_pair  = obs();
    end
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_valid", 64'(m_valid_o), 64'(0));
    check("reset_outs", {30'd0, m_sof_o, m_eol_o, m_data_o}, 64'(0));
    check("reset_sready", 64'(s_ready_o), 64'(1));
    rst_i = 1'b0;
    idle();

    // Even-length line
    send_beat(1, 1'b1, 1'b0);
    send_beat(2, 1'b0, 1'b0);
    check("l4_p1", 64'(obs()), 64'(mk(1'b0, 1'b1, 1, 2)));
    send_beat(3, 1'b0, 1'b0);
    send_beat(4, 1'b0, 1'b1);
    check("l4_p2", 64'(obs()), 64'(mk(1'b1, 1'b0, 3, 4)));
    idle();

    // Odd-length line with symmetric extension
    send_beat(1, 1'b1, 1'b0);
    send_beat(2, 1'b0, 1'b0);
    send_beat(3, 1'b0, 1'b0);
    send_beat(4, 1'b0, 1'b0);
    send_beat(5, 1'b0, 1'b1);
    check("l5_tail", 64'(obs()), 64'(mk(1'b1, 1'b0, 5, 4)));
    idle();

    // Single-sample line
    send_beat(7, 1'b1, 1'b1);
    check("l1_pair", 64'(obs()), 64'(mk(1'b1, 1'b1, 7, 7)));
    idle();

    // Output stall for 5 cycles
    m_ready_i = 1'b0;
    send_beat(16'h10, 1'b1, 1'b0);
    send_beat(16'h20, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle();
      check("stall_sready", 64'(s_ready_o), 64'(0));
      check("stall_pair", 64'(obs()), 64'(mk(1'b0, 1'b1, 16'h10, 16'h20)));
    end
    m_ready_i = 1'b1;
    send_beat(16'h30, 1'b0, 1'b0);
    send_beat(16'h40, 1'b0, 1'b1);
    check("stall_p2", 64'(obs()), 64'(mk(1'b1, 1'b0, 16'h30, 16'h40)));
    idle();

    // sof on the second beat of a line
`ifdef SAMPLE_PAIR_PACKER_LEN_CHECK_EN
    check("err_clear", 64'(err_o), 64'(0));
`endif
    send_beat(1, 1'b0, 1'b0);
    send_beat(9, 1'b1, 1'b0);
    send_beat(8, 1'b0, 1'b1);
    check("late_sof", 64'(obs()), 64'(mk(1'b1, 1'b1, 9, 8)));
    idle();
`ifdef SAMPLE_PAIR_PACKER_LEN_CHECK_EN
    check("err_set", 64'(err_o), 64'(1));
`endif

    // Reset while a pair is stalled in the output register
    m_ready_i = 1'b0;
    send_beat(1, 1'b1, 1'b0);
    send_beat(2, 1'b0, 1'b0);
    pulse_reset();
    m_ready_i = 1'b1;
`ifdef SAMPLE_PAIR_PACKER_LEN_CHECK_EN
    check("err_reset", 64'(err_o), 64'(0));
`endif

    // Reset while ODD holds sample 3
    send_beat(3, 1'b1, 1'b0);
    pulse_reset();
    send_beat(5, 1'b0, 1'b0);
    send_beat(6, 1'b0, 1'b1);
    check("post_rst_pair", 64'(obs()), 64'(mk(1'b1, 1'b0, 5, 6)));
    idle();

    // Randomized lines with random backpressure and occasional mid-line sof
    rand_ready = 1'b1;
    for (int l = 0; l < 60; l++) begin
      int len;
      bit fs;
      len = $urandom_range(1, 9);
      fs  = (l == 0) || ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) begin
        bit s;
        s = (i == 0 && fs) || (i > 0 && $urandom_range(0, 15) == 0);
        send_beat(int'($urandom_range(0, 65535)), s, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle();
      end
    end

    rand_ready = 1'b0;
    m_ready_i  = 1'b1;
    repeat (4) idle();
    check("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_pair_packer.md
SAMPLE_PAIR_PACKER -- requirements
Module: sample_pair_packer

Interface
REQ-001 SHALL have parameter DataWidth, default 16, meaning signed fixed-point sample width.
REQ-002 SHALL have parameter MaximumSideSize, default 512, meaning the maximum samples per line.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock.
REQ-004 SHALL have port rst_i, input, 1 bit; reset is asynchronous and active-high.
REQ-005 SHALL have port s_ready_o, output, 1 bit, input-stream ready.
REQ-006 SHALL have port s_valid_i, input, 1 bit, input-stream valid.
REQ-007 SHALL have port s_sof_i, input, 1 bit, first sample of frame.
REQ-008 SHALL have port s_eol_i, input, 1 bit, last sample of line.
REQ-009 SHALL have port s_data_i, input, DataWidth bits, one sample per beat.
REQ-010 SHALL have port m_ready_i, input, 1 bit, output-stream ready.
REQ-011 SHALL have port m_valid_o, output, 1 bit, output-stream valid.
REQ-012 SHALL have port m_sof_o, output, 1 bit, first pair of frame.
REQ-013 SHALL have port m_eol_o, output, 1 bit, last pair of line.
REQ-014 SHALL have port m_data_o, output, 2*DataWidth bits, {odd, even}, odd in upper half; it feeds the 1D lifting unit directly.

Function
REQ-015 SHALL transfer on either side only when valid and ready are both high in the same cycle.
REQ-016 SHALL drive s_ready_o = !m_valid_o | m_ready_i, with no dependency on s_valid_i or payload.
REQ-017 SHALL implement FSM states EVEN (awaiting even sample) and ODD (even sample held).
REQ-018 EVEN + accepted beat without eol: SHALL store sample in even_hold, latch its sof into sof_hold, go to ODD, emit nothing.
REQ-019 ODD + accepted beat: SHALL load the output register with {sample, even_hold}, sof=sof_hold, eol=s_eol_i, store sample in last_odd, go to EVEN.
REQ-020 EVEN + accepted beat with eol (odd-length line): SHALL emit {last_odd, sample} with eol=1 (whole-sample symmetric extension x[N]=x[N-2]), stay in EVEN.
REQ-021 Line of length 1 (sample carries both sof/line-start and eol in EVEN with no prior odd in the line): SHALL emit {sample, sample}.
REQ-022 Accepted beat with s_sof_i in ODD: SHALL discard even_hold and treat the beat as EVEN-state input.
REQ-023 SHALL clear last_odd validity at every line end so extension never crosses lines.
REQ-024 Latency: SHALL present a pair on m_*_o exactly 1 cycle after the completing input beat is accepted.
REQ-025 SHALL hold m_data_o, m_sof_o, m_eol_o stable while m_valid_o=1 and m_ready_i=0.
REQ-026 Output accepted and new pair loaded in same cycle: SHALL keep m_valid_o=1 without bubble, giving 1 pair/2 input beats throughput.

Reset
REQ-027 On rst_i=1: SHALL set FSM=EVEN, m_valid_o=0, m_sof_o=0, m_eol_o=0, m_data_o=0, holds cleared, s_ready_o=1 once m_valid_o=0.
REQ-028 Reset mid-line SHALL drop any held sample; the first post-reset beat is treated as even.

Configuration
REQ-029 Macro SAMPLE_PAIR_PACKER_LEN_CHECK_EN, when defined, SHALL add output err_o (1 bit, sticky until reset) and a clog2(MaximumSideSize+1)-bit per-line sample counter.
REQ-030 With it defined: err_o SHALL set when a line exceeds MaximumSideSize samples or sof arrives in ODD; data path unchanged.
REQ-031 Without it: no err_o port, no counter logic.

Structure
REQ-032 Typedef pair_t {eol, sof, even, odd} and FSM state enum SHALL live in shared package Dwt97Pkg.
REQ-033 The output register SHALL be the existing AxisReg sub-module; FSM and holds stay in this module.

Verification
REQ-034 Line 1,2,3,4 (sof on 1, eol on 4), m_ready_i=1 -> pairs {2,1} sof=1, then {4,3} eol=1.
REQ-035 Line 1,2,3,4,5 eol on 5 -> {2,1},{4,3},{4,5} eol=1.
REQ-036 Single-sample line 7 with sof+eol -> {7,7} sof=1 eol=1.
REQ-037 m_ready_i low for 5 cycles after first pair -> s_ready_o=0, m_data_o held, no loss or duplication.
REQ-038 sof asserted on 2nd beat of a line (1, 9sof, 8 eol) -> {8,9} sof=1 eol=1; err_o=1 when macro defined.
REQ-039 rst_i pulsed while ODD holds sample 3 -> m_valid_o=0 immediately; next beats 5,6 eol -> {6,5}.
